// File: rtl/fpu_exc_pkg.sv
// Shared definitions for the FPU exception pipeline: opcodes, operand classes
// and the canonical special-value bit patterns.
package fpu_exc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_DENORM,
    CLS_NORMAL,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } fp_class_e;

  typedef struct packed {
    fp_class_e cls;
    logic      sign;
  } operand_t;

  // Positive canonical quiet NaN: exponent all ones, mantissa MSB only.
  function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r = r | (64'd1 << (man_w - 1));
    return r;
  endfunction

  function automatic logic [63:0] inf_bits(input logic sign, input int exp_w, input int man_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r[exp_w + man_w] = sign;
    return r;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational decode of one IEEE-style operand into its class and sign.
module fp_classify
  import fpu_exc_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int MAN_WIDTH  = 23,
  parameter int DATA_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] num,
  output fp_class_e             cls,
  output logic                  sign
);

  logic [EXP_WIDTH-1:0] exp_f;
  logic [MAN_WIDTH-1:0] man_f;

  assign sign  = num[DATA_WIDTH-1];
  assign exp_f = num[DATA_WIDTH-2 -: EXP_WIDTH];
  assign man_f = num[MAN_WIDTH-1:0];

  always_comb begin
    if (exp_f == '1) begin
      if (man_f == '0)             cls = CLS_INF;
      else if (man_f[MAN_WIDTH-1]) cls = CLS_QNAN;
      else                         cls = CLS_SNAN;
    end else if (exp_f == '0) begin
      cls = (man_f == '0) ? CLS_ZERO : CLS_DENORM;
    end else begin
      cls = CLS_NORMAL;
    end
  end

endmodule

// File: rtl/fpu_exception_pipe.sv
// Two-stage pipeline that detects IEEE special cases for add/sub/mul/div,
// produces the special-case result and maintains sticky exception flags.
module fpu_exception_pipe
  import fpu_exc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int EXP_WIDTH  = 8,
  parameter int MAN_WIDTH  = 23,
  parameter int OP_WIDTH   = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] float_num1,
  input  logic [DATA_WIDTH-1:0] float_num2,
  input  logic [OP_WIDTH-1:0]   opcode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel,
  output logic [DATA_WIDTH-1:0] exception_out,
  input  logic                  flags_clr,
  output logic                  flag_invalid,
  output logic                  flag_divzero,
  output logic                  flag_inf,
  output logic [CNT_WIDTH-1:0]  exc_count
);

  localparam logic [63:0] QNAN_W = qnan_bits(EXP_WIDTH, MAN_WIDTH);
  localparam logic [63:0] INF_W  = inf_bits(1'b0, EXP_WIDTH, MAN_WIDTH);
  localparam logic [DATA_WIDTH-1:0] QNAN = QNAN_W[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-2:0] INF_MAG = INF_W[DATA_WIDTH-2:0];

  operand_t            in_a, in_b;
  logic                advance, handshake;
  logic                s1_valid;
  operand_t            s1_a, s1_b;
  logic [OP_WIDTH-1:0] s1_op;
  logic                ev_invalid, ev_divzero, ev_inf;

  fp_classify #(.EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH), .DATA_WIDTH(DATA_WIDTH))
    u_class_a (.num(float_num1), .cls(in_a.cls), .sign(in_a.sign));
  fp_classify #(.EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH), .DATA_WIDTH(DATA_WIDTH))
    u_class_b (.num(float_num2), .cls(in_b.cls), .sign(in_b.sign));

  assign advance   = !(out_valid && !out_ready);
  assign in_ready  = advance;
  assign handshake = out_valid && out_ready;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '{cls: CLS_ZERO, sign: 1'b0};
      s1_b     <= '{cls: CLS_ZERO, sign: 1'b0};
      s1_op    <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_op    <= opcode;
      s1_a     <= in_a;
      // Subtraction is an add with the second operand negated.
      s1_b     <= '{cls: in_b.cls, sign: in_b.sign ^ (opcode == OP_SUB)};
    end
  end

  logic                  d_sel, d_inv, d_dz, d_inf;
  logic [DATA_WIDTH-1:0] d_exc;
  logic                  z_a, z_b, i_a, i_b, n_a, n_b, sx;

  // Denormals are folded into zero before any rule is applied.
  assign z_a = (s1_a.cls == CLS_ZERO) || (s1_a.cls == CLS_DENORM);
  assign z_b = (s1_b.cls == CLS_ZERO) || (s1_b.cls == CLS_DENORM);
  assign i_a = (s1_a.cls == CLS_INF);
  assign i_b = (s1_b.cls == CLS_INF);
  assign n_a = (s1_a.cls == CLS_QNAN) || (s1_a.cls == CLS_SNAN);
  assign n_b = (s1_b.cls == CLS_QNAN) || (s1_b.cls == CLS_SNAN);
  assign sx  = s1_a.sign ^ s1_b.sign;

  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    d_sel = 1'b1;
    d_exc = '0;
    d_inv = 1'b0;
    d_dz  = 1'b0;
    d_inf = 1'b0;
    if (!s1_valid) begin
      d_sel = 1'b1;
    end else if (n_a || n_b) begin
      d_sel = 1'b0;
      d_exc = QNAN;
      d_inv = (s1_a.cls == CLS_SNAN) || (s1_b.cls == CLS_SNAN);
    end else begin
      case (s1_op)
        OP_ADD, OP_SUB: begin
          if (i_a && i_b && (s1_a.sign != s1_b.sign)) begin
            d_sel = 1'b0; d_exc = QNAN; d_inv = 1'b1;
          end else if (i_a || i_b) begin
            d_sel = 1'b0; d_inf = 1'b1;
            d_exc = {(i_a ? s1_a.sign : s1_b.sign), INF_MAG};
          end
        end
        OP_MUL: begin
          if ((z_a && i_b) || (i_a && z_b)) begin
            d_sel = 1'b0; d_exc = QNAN; d_inv = 1'b1;
          end else if (i_a || i_b) begin
            d_sel = 1'b0; d_inf = 1'b1; d_exc = {sx, INF_MAG};
          end else if (z_a || z_b) begin
            d_sel = 1'b0; d_exc = {sx, {(DATA_WIDTH-1){1'b0}}};
          end
        end
        default: begin
          if ((z_a && z_b) || (i_a && i_b)) begin
            d_sel = 1'b0; d_exc = QNAN; d_inv = 1'b1;
          end else if (i_a) begin
            d_sel = 1'b0; d_inf = 1'b1; d_exc = {sx, INF_MAG};
          end else if (z_b) begin
            d_sel = 1'b0; d_inf = 1'b1; d_dz = 1'b1; d_exc = {sx, INF_MAG};
          end else if (i_b || z_a) begin
            d_sel = 1'b0; d_exc = {sx, {(DATA_WIDTH-1){1'b0}}};
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      sel           <= 1'b1;
      exception_out <= '0;
      ev_invalid    <= 1'b0;
      ev_divzero    <= 1'b0;
      ev_inf        <= 1'b0;
    end else if (advance) begin
      out_valid     <= s1_valid;
      sel           <= d_sel;
      exception_out <= d_exc;
      ev_invalid    <= d_inv;
      ev_divzero    <= d_dz;
      ev_inf        <= d_inf;
    end
  end

  logic [CNT_WIDTH-1:0] cnt_base;
  assign cnt_base = flags_clr ? '0 : exc_count;

  // A new event on the handshake beat always wins over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_invalid <= 1'b0;
      flag_divzero <= 1'b0;
      flag_inf     <= 1'b0;
      exc_count    <= '0;
    end else if (handshake) begin
      flag_invalid <= (flag_invalid && !flags_clr) || ev_invalid;
      flag_divzero <= (flag_divzero && !flags_clr) || ev_divzero;
      flag_inf     <= (flag_inf && !flags_clr) || ev_inf;
      exc_count    <= (!sel && !(&cnt_base)) ? cnt_base + 1'b1 : cnt_base;
    end else if (flags_clr) begin
      flag_invalid <= 1'b0;
      flag_divzero <= 1'b0;
      flag_inf     <= 1'b0;
      exc_count    <= '0;
    end
  end

endmodule

// File: doc/fpu_exception_pipe.md
FPU_EXCEPTION_PIPE -- requirements
Module: fpu_exception_pipe

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, operand/result width; EXP_WIDTH, 8, exponent bits; MAN_WIDTH, 23, mantissa bits (DATA_WIDTH = 1+EXP_WIDTH+MAN_WIDTH); OP_WIDTH, 2, opcode width; CNT_WIDTH, 16, exception counter width.
REQ-002 Ports SHALL be: clk in 1 clock; rst in 1 asynchronous active-high reset.
REQ-003 Ports: in_valid in 1 operand beat valid; in_ready out 1 beat accepted when in_valid&in_ready.
REQ-004 Ports: float_num1, float_num2 in DATA_WIDTH operands; opcode in OP_WIDTH (00 add, 01 sub, 10 mul, 11 div).
REQ-005 Ports: out_valid out 1; out_ready in 1; sel out 1 (1 = normal datapath result, 0 = exception_out used); exception_out out DATA_WIDTH special-case result (0 when sel=1).
REQ-006 Ports: flags_clr in 1; flag_invalid, flag_divzero, flag_inf out 1 each sticky; exc_count out CNT_WIDTH.

Function
REQ-007 The block SHALL be a 2-stage pipeline: stage 1 registers operand classes (zero, denormal, normal, inf, qNaN, sNaN, sign) and opcode; stage 2 registers sel/exception_out/event bits; latency 2 cycles with no stall.
REQ-008 Pipeline SHALL stall globally when out_valid=1 and out_ready=0; in_ready = !(out_valid & !out_ready); stalled stages hold contents unchanged.
REQ-009 Bubbles SHALL propagate: a stage with no valid beat advances when downstream accepts, so throughput is 1 beat/cycle with out_ready held high.
REQ-010 Denormal operands SHALL be treated as signed zero (DAZ).
REQ-011 For sub, the sign of float_num2 SHALL be inverted, then add rules applied.
REQ-012 Any NaN operand SHALL give sel=0, exception_out=canonical qNaN (0x7FC00000 for default widths: sign 0, exponent all ones, mantissa MSB only); sNaN operand additionally raises invalid event.
REQ-013 Add: +Inf plus -Inf -> qNaN, invalid; one Inf -> that Inf; both Inf same sign -> that Inf; otherwise sel=1.
REQ-014 Mul: zero*Inf -> qNaN, invalid; Inf*non-zero -> Inf with sign XOR; zero*finite -> zero with sign XOR; otherwise sel=1.
REQ-015 Div: 0/0 or Inf/Inf -> qNaN, invalid; finite non-zero/0 -> Inf sign XOR, divzero; Inf/finite -> Inf sign XOR; finite/Inf or 0/finite non-zero -> zero sign XOR; otherwise sel=1.
REQ-016 Inf event SHALL be raised whenever exception_out is an Inf.
REQ-017 Sticky flags SHALL update only on output handshake (out_valid&out_ready): flag <= (flag & !flags_clr) | event; new event wins over simultaneous clear.
REQ-018 flags_clr without handshake SHALL clear all flags and exc_count next cycle.
REQ-019 exc_count SHALL increment by 1 per handshake with sel=0, saturate at all ones, and follow the REQ-017 rule with clear (clear+exception in same cycle -> 1).
REQ-020 Outputs SHALL be driven from registers only; no combinational path from inputs to outputs except in_ready from out_ready.

Reset
REQ-021 rst SHALL asynchronously clear both stage valids, out_valid=0, sel=1, exception_out=0, all flags=0, exc_count=0; in_ready=1 during and after reset.
REQ-022 Beats in flight at reset SHALL be discarded; no output handshake occurs until a new beat is accepted after rst deasserts.

Structure
REQ-023 A shared package fpu_exc_pkg SHALL hold opcode encodings, operand class enumeration, and the canonical qNaN/Inf constant functions of EXP_WIDTH/MAN_WIDTH.
REQ-024 One sub-module fp_classify (combinational, parametrised, instantiated twice) SHALL decode an operand into class and sign.

Verification
REQ-025 add 0x7F800000 + 0xFF800000, out_ready=1 -> 2 cycles later out_valid, sel=0, exception_out=0x7FC00000, flag_invalid=1, exc_count=1.
REQ-026 div 0x3F800000 / 0x80000000 -> sel=0, exception_out=0xFF800000, flag_divzero=1, flag_inf=1.
REQ-027 mul 0x40000000 * 0x40400000 -> sel=1, exception_out=0, no flags, exc_count unchanged.
REQ-028 back-to-back 4 beats, out_ready low 3 cycles mid-stream -> in_ready low during stall, no beat lost/duplicated, order preserved.
REQ-029 flags_clr coincident with handshake of sub 0x7F800000 - 0x7F800000 -> flag_invalid stays 1, exc_count=1; rst mid-stream -> all outputs at reset values immediately.
